pc_sequencer: RTL and testbench

- Owns the program counter register of the single-cycle MIPS core and sequences it each cycle.
- Selects the next PC from sequential (PC+4), conditional branch, J/JAL and JR targets.
- Holds the PC under stall, defers a redirect raised during stall, and halts on an illegal fetch address.
- Drives the instruction-memory address and the PC+4 value used for the JAL link write.

---
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer for the single-cycle MIPS core.
// Handles stall holding, deferred redirects and a sticky fault on illegal fetch addresses.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic [1:0]  npc_op_i,
    input  logic        br_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        redirect_pending_o,
    output logic        fetch_fault_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] commit_count_o
);

    // 33-bit exclusive upper bound so IM_BASE + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] ImLimit = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    typedef enum logic [1:0] {StRun, StHold, StFault} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] hold_q;
    logic [31:0] fault_addr_q;
    logic [31:0] count_q;

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] new_target;
    logic [31:0] commit_target;
    logic        redirect;
    logic        legal;

    always_comb begin
        pc4       = pc_q + 32'd4;
        br_target = pc4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
        j_target  = {pc_q[31:28], instr_index_i, 2'b00};
        redirect  = npc_op_i[1] | ((npc_op_i == 2'b01) & br_taken_i);

        new_target = pc4;
        unique case (npc_op_i)
            2'b00: new_target = pc4;
            2'b01: new_target = br_taken_i ? br_target : pc4;
            2'b10: new_target = j_target;
            2'b11: new_target = rs_data_i;
        endcase

        // While holding, the deferred redirect is the only candidate.
        commit_target = (state_q == StHold) ? hold_q : new_target;
        legal = (commit_target[1:0] == 2'b00) && (commit_target >= IM_BASE) &&
                ({1'b0, commit_target} < ImLimit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            hold_q       <= 32'd0;
            fault_addr_q <= 32'd0;
            count_q      <= 32'd0;
        end else begin
            case (state_q)
                StRun: begin
                    if (!stall_i) begin
                        if (legal) begin
                            pc_q    <= commit_target;
                            count_q <= count_q + 32'd1;
                        end else begin
                            fault_addr_q <= commit_target;
                            state_q      <= StFault;
                        end
                    end else if (redirect) begin
                        hold_q  <= new_target;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (!stall_i) begin
                        if (legal) begin
                            pc_q    <= commit_target;
                            count_q <= count_q + 32'd1;
                            state_q <= StRun;
                        end else begin
                            fault_addr_q <= commit_target;
                            state_q      <= StFault;
                        end
                    end
                end
                StFault: state_q <= StFault;
                default: state_q <= StFault;
            endcase
        end
    end

    assign pc_o               = pc_q;
    assign pc4_o              = pc4;
    assign redirect_pending_o = (state_q == StHold);
    assign fetch_fault_o      = (state_q == StFault);
    assign fault_addr_o       = fault_addr_q;
    assign commit_count_o     = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario-driven bench for pc_sequencer: expected fetch state is queued as stimulus
// is applied and popped for comparison once the committing edge has passed.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [1:0]  npc_op_i = 2'b00;
    logic        br_taken_i = 1'b0;
    logic [15:0] imm16_i = 16'h0;
    logic [25:0] instr_index_i = 26'h0;
    logic [31:0] rs_data_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        redirect_pending_o;
    logic        fetch_fault_o;
    logic [31:0] fault_addr_o;
    logic [31:0] commit_count_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        pend;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    pc_sequencer dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .stall_i            (stall_i),
        .npc_op_i           (npc_op_i),
        .br_taken_i         (br_taken_i),
        .imm16_i            (imm16_i),
        .instr_index_i      (instr_index_i),
        .rs_data_i          (rs_data_i),
        .pc_o               (pc_o),
        .pc4_o              (pc4_o),
        .redirect_pending_o (redirect_pending_o),
        .fetch_fault_o      (fetch_fault_o),
        .fault_addr_o       (fault_addr_o),
        .commit_count_o     (commit_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic s, input logic [1:0] op, input logic tk,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
        stall_i       = s;
        npc_op_i      = op;
        br_taken_i    = tk;
        imm16_i       = imm;
        instr_index_i = idx;
        rs_data_i     = rs;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc_o, redirect_pending_o, fetch_fault_o, fault_addr_o, commit_count_o} !==
            {32'h0000_3000, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset: got pc=%h pend=%b flt=%b faddr=%h cnt=%0d, want 3000/0/0/0/0",
                     pc_o, redirect_pending_o, fetch_fault_o, fault_addr_o, commit_count_o);
        end
        checks++;
        if (pc4_o !== 32'h0000_3004) begin
            errors++;
            $display("FAIL reset_pc4: got %h want 00003004", pc4_o);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
            sb.push_back({32'h0000_3004 + 32'(4 * i), 1'b0, 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc_o, redirect_pending_o, fetch_fault_o} !== {e.pc, e.pend, e.flt}) begin
                errors++;
                $display("FAIL seq[%0d]: got pc=%h pend=%b flt=%b want pc=%h pend=%b flt=%b",
                         i, pc_o, redirect_pending_o, fetch_fault_o, e.pc, e.pend, e.flt);
            end
        end
        checks++;
        if (commit_count_o !== 32'd3) begin
            errors++;
            $display("FAIL seq_count: got %0d want 3", commit_count_o);
        end
    endtask

    task automatic test_branch();
        logic [1:0]  op [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        logic        tk [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ex [4] = '{32'h3010, 32'h300C, 32'h3010, 32'h3014};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, op[i], tk[i], 16'hFFFE, 26'h0, 32'h0);
            sb.push_back({ex[i], 1'b0, 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc_o, redirect_pending_o, fetch_fault_o} !== {e.pc, e.pend, e.flt}) begin
                errors++;
                $display("FAIL branch[%0d]: got pc=%h pend=%b flt=%b want pc=%h pend=%b flt=%b",
                         i, pc_o, redirect_pending_o, fetch_fault_o, e.pc, e.pend, e.flt);
            end
        end
        checks++;
        if (commit_count_o !== 32'd7) begin
            errors++;
            $display("FAIL branch_count: got %0d want 7", commit_count_o);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(1'b0, 2'b10, 1'b0, 16'h0, 26'h0000C40, 32'h0);
                sb.push_back({32'h0000_3100, 1'b0, 1'b0});
            end else begin
                drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3200);
                sb.push_back({32'h0000_3200, 1'b0, 1'b0});
            end
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc_o, redirect_pending_o, fetch_fault_o} !== {e.pc, e.pend, e.flt}) begin
                errors++;
                $display("FAIL jump[%0d]: got pc=%h pend=%b flt=%b want pc=%h pend=%b flt=%b",
                         i, pc_o, redirect_pending_o, fetch_fault_o, e.pc, e.pend, e.flt);
            end
        end
        checks++;
        if (commit_count_o !== 32'd2) begin
            errors++;
            $display("FAIL jump_count: got %0d want 2", commit_count_o);
        end
    endtask

    // Entered at pc=0x3200, count=2.
    task automatic test_stall_redirect();
        logic        st [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  op [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
        logic [31:0] rs [6] = '{32'h3400, 32'h3800, 32'h3800, 32'h3800, 32'h0, 32'h0};
        logic [31:0] ex [6] = '{32'h3200, 32'h3200, 32'h3200, 32'h3400, 32'h3400, 32'h3400};
        logic        pd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(st[i], op[i], 1'b0, 16'h0004, 26'h0, rs[i]);
            sb.push_back({ex[i], pd[i], 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc_o, redirect_pending_o, fetch_fault_o} !== {e.pc, e.pend, e.flt}) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h pend=%b flt=%b want pc=%h pend=%b flt=%b",
                         i, pc_o, redirect_pending_o, fetch_fault_o, e.pc, e.pend, e.flt);
            end
        end
        checks++;
        if (commit_count_o !== 32'd3) begin
            errors++;
            $display("FAIL stall_count: got %0d want 3", commit_count_o);
        end
    endtask

    // Entered at pc=0x3400, count=3.
    task automatic test_fault();
        exp_t e;
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3402);
        sb.push_back({32'h0000_3400, 1'b0, 1'b1});
        for (int i = 0; i < 5; i++) sb.push_back({32'h0000_3400, 1'b0, 1'b1});
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                             26'($urandom), $urandom);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc_o, redirect_pending_o, fetch_fault_o} !== {e.pc, e.pend, e.flt}) begin
                errors++;
                $display("FAIL fault[%0d]: got pc=%h pend=%b flt=%b want pc=%h pend=%b flt=%b",
                         i, pc_o, redirect_pending_o, fetch_fault_o, e.pc, e.pend, e.flt);
            end
        end
        checks++;
        if ({fault_addr_o, commit_count_o} !== {32'h0000_3402, 32'd3}) begin
            errors++;
            $display("FAIL fault_frozen: got faddr=%h cnt=%0d want 00003402/3",
                     fault_addr_o, commit_count_o);
        end
        do_reset();
        checks++;
        if ({pc_o, fetch_fault_o, fault_addr_o} !== {32'h0000_3000, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fault_reset: got pc=%h flt=%b faddr=%h want 00003000/0/0",
                     pc_o, fetch_fault_o, fault_addr_o);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] rs [3] = '{32'h6FFC, 32'h2FFC, 32'h3000};
        logic [31:0] ex [3] = '{32'h6FFC, 32'h3000, 32'h3000};
        logic        fl [3] = '{1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, rs[i]);
            sb.push_back({ex[i], 1'b0, fl[i]});
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc_o, redirect_pending_o, fetch_fault_o} !== {e.pc, e.pend, e.flt}) begin
                errors++;
                $display("FAIL bound[%0d]: got pc=%h pend=%b flt=%b want pc=%h pend=%b flt=%b",
                         i, pc_o, redirect_pending_o, fetch_fault_o, e.pc, e.pend, e.flt);
            end
            if (i == 0) begin
                checks++;
                if (pc4_o !== 32'h0000_7000) begin
                    errors++;
                    $display("FAIL top_pc4: got %h want 00007000", pc4_o);
                end
                drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
                tick();
                checks++;
                if ({pc_o, fetch_fault_o, fault_addr_o} !== {32'h6FFC, 1'b1, 32'h7000}) begin
                    errors++;
                    $display("FAIL top_step: got pc=%h flt=%b faddr=%h want 00006ffc/1/00007000",
                             pc_o, fetch_fault_o, fault_addr_o);
                end
            end
        end
    endtask

    task automatic test_hold_fault();
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_8000);
        tick();
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        tick();
        checks++;
        if ({pc_o, redirect_pending_o, fetch_fault_o, fault_addr_o} !==
            {32'h3000, 1'b0, 1'b1, 32'h8000}) begin
            errors++;
            $display("FAIL hold_fault: got pc=%h pend=%b flt=%b faddr=%h want 3000/0/1/8000",
                     pc_o, redirect_pending_o, fetch_fault_o, fault_addr_o);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        drive(1'b1, 2'b10, 1'b0, 16'h0, 26'h0000C40, 32'h0);
        tick();
        checks++;
        if ({pc_o, redirect_pending_o} !== {32'h3000, 1'b1}) begin
            errors++;
            $display("FAIL hold_enter: got pc=%h pend=%b want 00003000/1", pc_o, redirect_pending_o);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++;
        if ({pc_o, redirect_pending_o} !== {32'h3000, 1'b0}) begin
            errors++;
            $display("FAIL hold_reset: got pc=%h pend=%b want 00003000/0", pc_o, redirect_pending_o);
        end
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        tick();
        checks++;
        if ({pc_o, commit_count_o} !== {32'h3004, 32'd1}) begin
            errors++;
            $display("FAIL hold_discard: got pc=%h cnt=%0d want 00003004/1", pc_o, commit_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_redirect();
        test_fault();
        test_boundaries();
        test_hold_fault();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
